// File: rtl/demux_4out_buffered.sv
// demux_4out_buffered: routes input words to four one-entry buffered channels.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   S, D         destination channel select and data word
//   in_valid     input word present
//   in_ready     block can accept the word addressed by S
//   Q, q_valid   per-channel data (channel n at [n*W +: W]) and valid
//   q_ack        per-channel consumer acknowledge
//   err          one-cycle pulse when an accepted word is dropped
//   drop_cnt     saturating count of dropped words
// Build macro DEMUX_CH3_EN: channel 3 becomes a normal buffer.
// Without it, words addressed to channel 3 are accepted and dropped.
module demux_4out_buffered #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       S,
  input  logic [W-1:0]     D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [4*W-1:0]   Q,
  output logic [3:0]       q_valid,
  input  logic [3:0]       q_ack,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

`ifdef DEMUX_CH3_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic [3:0]     vld_q, vld_d;
  logic [4*W-1:0] dat_q, dat_d;
  logic           acc;

  // A full channel can take a new word in the
  // same cycle its consumer acknowledges.
  // An unbuffered channel 3 is never valid,
  // so it always reads as ready.
  assign in_ready = ~vld_q[S] | q_ack[S];
  assign acc      = in_valid & in_ready;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int n = 0; n < NB; n++) begin
      if (acc && (S == 2'(n))) begin
        vld_d[n]       = 1'b1;
        dat_d[n*W +: W] = D;
      end else if (q_ack[n]) begin
        vld_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign q_valid = vld_q;
  assign Q       = dat_q;

`ifdef DEMUX_CH3_EN
  assign err      = 1'b0;
  assign drop_cnt = '0;
`else
  logic             drop;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign drop = acc & (S == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    if (drop && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop;
      cnt_q <= cnt_d;
    end
  end

  assign err      = err_q;
  assign drop_cnt = cnt_q;
`endif

endmodule
